// File: rtl/rvm_ifu_if.sv
// Fetch-side and memory-side signals of rvm_ifu bundled as one interface.
// master: the fetch unit's view; slave: the control FSM and instruction memory.
interface rvm_ifu_if;
  logic        fetch_req;
  logic [31:0] pc;
  logic        fetch_busy;
  logic        fetch_done;
  logic        fetch_error;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    input  fetch_req, pc, mem_gnt, mem_rvalid, mem_rdata, mem_err,
    output fetch_busy, fetch_done, fetch_error, instr, instr_pc, pc_plus4, mem_req, mem_addr
  );

  modport slave (
    output fetch_req, pc, mem_gnt, mem_rvalid, mem_rdata, mem_err,
    input  fetch_busy, fetch_done, fetch_error, instr, instr_pc, pc_plus4, mem_req, mem_addr
  );
endinterface

// File: rtl/rvm_ifu.sv
// Instruction fetch unit: one word fetch per request over a req/gnt/rvalid port.
// Define RVM_IFU_ALIGN_CHECK_EN to fault misaligned pc values without a memory access.
module rvm_ifu (
  input  logic      clk,
  input  logic      resetn,
  rvm_ifu_if.master bus
);

  localparam logic [31:0] RVM_IFU_INSTR_RESET = 32'h0000_0013;
  localparam logic [31:0] RVM_IFU_PC_RESET    = 32'h0000_0000;

`ifdef RVM_IFU_ALIGN_CHECK_EN
  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StErr} state_e;
`else
  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;
`endif

  state_e      r_state, w_state_next;
  logic [31:0] r_addr, w_addr_next;
  logic [31:0] r_instr, w_instr_next;
  logic [31:0] r_instr_pc, w_instr_pc_next;
  logic        r_err, w_err_next;
  logic [31:0] w_fetch_addr;
  logic        w_misaligned;

`ifdef RVM_IFU_ALIGN_CHECK_EN
  assign w_fetch_addr = bus.pc;
  assign w_misaligned = |bus.pc[1:0];
`else
  // Low pc bits are dropped so instr_pc reports the word address actually fetched.
  assign w_fetch_addr = bus.pc & ~32'h3;
  assign w_misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= StIdle;
      r_addr     <= RVM_IFU_PC_RESET;
      r_instr    <= RVM_IFU_INSTR_RESET;
      r_instr_pc <= RVM_IFU_PC_RESET;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_addr     <= w_addr_next;
      r_instr    <= w_instr_next;
      r_instr_pc <= w_instr_pc_next;
      r_err      <= w_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_addr_next     = r_addr;
    w_instr_next    = r_instr;
    w_instr_pc_next = r_instr_pc;
    w_err_next      = r_err;
    unique case (r_state)
      StIdle: begin
        if (bus.fetch_req) begin
          w_addr_next = w_fetch_addr;
          w_err_next  = 1'b0;
`ifdef RVM_IFU_ALIGN_CHECK_EN
          if (w_misaligned) begin
            w_state_next    = StErr;
            w_instr_pc_next = w_fetch_addr;
          end else begin
            w_state_next = StReq;
          end
`else
          w_state_next = w_misaligned ? StIdle : StReq;
`endif
        end
      end
      StReq: begin
        if (bus.mem_gnt) w_state_next = StWait;
      end
      StWait: begin
        if (bus.mem_rvalid) begin
          w_instr_pc_next = r_addr;
          w_err_next      = bus.mem_err;
          // A faulted response must not disturb the instruction register.
          if (!bus.mem_err) w_instr_next = bus.mem_rdata;
          w_state_next = StDone;
        end
      end
      StDone: w_state_next = StIdle;
`ifdef RVM_IFU_ALIGN_CHECK_EN
      StErr:  w_state_next = StIdle;
`endif
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    bus.fetch_busy  = (r_state != StIdle);
    bus.fetch_done  = (r_state == StDone);
    bus.fetch_error = (r_state == StDone) && r_err;
`ifdef RVM_IFU_ALIGN_CHECK_EN
    if (r_state == StErr) begin
      bus.fetch_done  = 1'b1;
      bus.fetch_error = 1'b1;
    end
`endif
    bus.mem_req  = (r_state == StReq);
    bus.mem_addr = {r_addr[31:2], 2'b00};
    bus.instr    = r_instr;
    bus.instr_pc = r_instr_pc;
    bus.pc_plus4 = r_instr_pc + 32'd4;
  end

endmodule

// File: tb/tb_rvm_ifu.sv
// Randomized bench for rvm_ifu: the bench plays control FSM and memory, and checks
// against a transaction-level model of the architectural instr/instr_pc registers.
module tb_rvm_ifu;

  localparam logic [31:0] Nop = 32'h0000_0013;
`ifdef RVM_IFU_ALIGN_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic clk;
  logic resetn;
  rvm_ifu_if bus_if ();

  rvm_ifu dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural state visible after each completed fetch.
  logic [31:0] m_instr;
  logic [31:0] m_instr_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.fetch_req  = 1'b0;
    bus_if.mem_gnt    = 1'b0;
    bus_if.mem_rvalid = 1'b0;
    bus_if.mem_err    = 1'b0;
    bus_if.mem_rdata  = $urandom;
  endtask

  task automatic check_arch(input string tag);
    check({tag, ".instr"}, bus_if.instr, m_instr);
    check({tag, ".instr_pc"}, bus_if.instr_pc, m_instr_pc);
    check({tag, ".pc_plus4"}, bus_if.pc_plus4, m_instr_pc + 32'd4);
  endtask

  // One fetch: gd cycles without grant, rd cycles in WAIT before the response.
  task automatic do_fetch(input logic [31:0] a, input int gd, input int rd, input logic e,
                          input logic [31:0] d);
    logic [31:0] word_addr;
    int          latency;
    int          done_cnt;
    word_addr = {a[31:2], 2'b00};
    check("start.busy", {31'b0, bus_if.fetch_busy}, 32'd0);
    bus_if.fetch_req = 1'b1;
    bus_if.pc        = a;
    tick();
    bus_if.fetch_req = 1'b0;
    bus_if.pc        = $urandom;
    if (ChkEn && a[1:0] != 2'b00) begin
      m_instr_pc = a;
      check("mis.done", {31'b0, bus_if.fetch_done}, 32'd1);
      check("mis.error", {31'b0, bus_if.fetch_error}, 32'd1);
      check("mis.req", {31'b0, bus_if.mem_req}, 32'd0);
      check_arch("mis");
      tick();
      check("mis.after", {30'b0, bus_if.fetch_busy, bus_if.fetch_done}, 32'd0);
      return;
    end
    latency  = 1;
    done_cnt = 0;
    for (int i = 0; i <= gd; i++) begin
      check("req.mem_req", {31'b0, bus_if.mem_req}, 32'd1);
      check("req.mem_addr", bus_if.mem_addr, word_addr);
      check_arch("req");
      done_cnt += int'(bus_if.fetch_done);
      bus_if.mem_gnt    = (i == gd);
      bus_if.mem_rvalid = 1'b0;
      tick();
      latency++;
    end
    bus_if.mem_gnt = 1'b0;
    for (int j = 0; j <= rd; j++) begin
      check("wait.mem_req", {31'b0, bus_if.mem_req}, 32'd0);
      check_arch("wait");
      done_cnt += int'(bus_if.fetch_done);
      bus_if.fetch_req  = 1'($urandom_range(0, 1));
      bus_if.mem_rvalid = (j == rd);
      bus_if.mem_err    = (j == rd) ? e : 1'($urandom_range(0, 1));
      bus_if.mem_rdata  = (j == rd) ? d : $urandom;
      tick();
      latency++;
    end
    idle_inputs();
    m_instr_pc = word_addr;
    if (!e) m_instr = d;
    check("done.pulses_before", done_cnt, 32'd0);
    check("done.latency", latency, 3 + gd + rd);
    check("done.done", {31'b0, bus_if.fetch_done}, 32'd1);
    check("done.error", {31'b0, bus_if.fetch_error}, {31'b0, e});
    check_arch("done");
    tick();
    check("after.done_busy", {30'b0, bus_if.fetch_busy, bus_if.fetch_done}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    resetn    = 1'b0;
    bus_if.pc = 32'h0;
    idle_inputs();
    m_instr    = Nop;
    m_instr_pc = 32'h0;
    #12;
    check("rst.mem_req", {31'b0, bus_if.mem_req}, 32'd0);
    check("rst.mem_addr", bus_if.mem_addr, 32'h0);
    check("rst.flags", {29'b0, bus_if.fetch_busy, bus_if.fetch_done, bus_if.fetch_error},
          32'd0);
    check_arch("rst");
    tick();
    resetn = 1'b1;
    tick();

    do_fetch(32'h0000_0100, 0, 0, 1'b0, 32'h0050_0093);
    do_fetch(32'h0000_0200, 3, 2, 1'b0, 32'h1234_5678);
    do_fetch(32'h0000_0300, 1, 1, 1'b1, 32'hDEAD_BEEF);
    do_fetch(32'h0000_0102, 0, 0, 1'b0, 32'h00A0_0113);
    do_fetch(32'hFFFF_FFFC, 0, 1, 1'b0, 32'hCAFE_F00D);
    check("wrap.pc_plus4", bus_if.pc_plus4, 32'h0);

    // Spurious response in IDLE must not change anything.
    bus_if.mem_rvalid = 1'b1;
    bus_if.mem_rdata  = 32'h5555_AAAA;
    tick();
    idle_inputs();
    check("spur.busy", {30'b0, bus_if.fetch_busy, bus_if.fetch_done}, 32'd0);
    check_arch("spur");

    for (int k = 0; k < 40; k++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_fetch(a, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0),
               $urandom);
    end

    // Asynchronous reset in the middle of REQ.
    bus_if.fetch_req = 1'b1;
    bus_if.pc        = 32'h0000_0400;
    tick();
    bus_if.fetch_req = 1'b0;
    check("mid.mem_req_pre", {31'b0, bus_if.mem_req}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    m_instr    = Nop;
    m_instr_pc = 32'h0;
    check("mid.mem_req", {31'b0, bus_if.mem_req}, 32'd0);
    check("mid.busy", {31'b0, bus_if.fetch_busy}, 32'd0);
    check_arch("mid");
    tick();
    resetn = 1'b1;
    bus_if.mem_rvalid = 1'b1;
    bus_if.mem_rdata  = 32'h0BAD_0BAD;
    tick();
    idle_inputs();
    check("late.flags", {29'b0, bus_if.fetch_busy, bus_if.fetch_done, bus_if.mem_req}, 32'd0);
    check_arch("late");
    do_fetch(32'h0000_0500, 0, 0, 1'b0, 32'h0010_0093);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
